// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, default latencies, op classing.
// MDU_MADD_EN turns opcodes 0110-1001 into multiply-accumulate ops; otherwise they are reserved.
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MADD  = 4'b0110;
    localparam logic [3:0] OP_MADDU = 4'b0111;
    localparam logic [3:0] OP_MSUB  = 4'b1000;
    localparam logic [3:0] OP_MSUBU = 4'b1001;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_MULT,
        CLS_DIV,
        CLS_MOVE
    } op_class_t;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t cls;
        case (op)
            OP_MULT, OP_MULTU: cls = CLS_MULT;
            OP_DIV, OP_DIVU:   cls = CLS_DIV;
            OP_MTHI, OP_MTLO:  cls = CLS_MOVE;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MULT;
`endif
            default:           cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    function automatic logic op_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair; result computed at launch, committed after N cycles.
// With MDU_MADD_EN defined, MADD/MADDU/MSUB/MSUBU accumulate into {HI,LO}; otherwise they are no-ops.
//
// state   | meaning
// IDLE    | no operation in flight; accepts Start, MTHI/MTLO write directly
// BUSY    | counting down; HI/LO take the pending result when the counter hits 1
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CMAX  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_ok_q, pend_ok_d;

    op_class_t        cls;
    logic             is_signed, launch, commit;
    logic             a_neg, b_neg;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic [WIDTH-1:0] a_mag, b_mag, b_div, quo, rem, quo_s, rem_s;

    assign cls       = op_class(MDUOp);
    assign is_signed = op_signed(MDUOp);
    assign launch    = (state_q == ST_IDLE) && Start && ((cls == CLS_MULT) || (cls == CLS_DIV));
    assign commit    = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));

    // Sign-extended operands give the signed product modulo 2^(2W) with a plain multiply.
    always_comb begin
        a_ext = is_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        b_ext = is_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        prod  = a_ext * b_ext;
        a_neg = is_signed & A[WIDTH-1];
        b_neg = is_signed & B[WIDTH-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
        b_div = (b_mag == '0) ? WIDTH'(1) : b_mag;
        quo   = a_mag / b_div;
        rem   = a_mag % b_div;
        quo_s = (a_neg ^ b_neg) ? -quo : quo;
        rem_s = a_neg ? -rem : rem;
    end

`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] acc_sum;
    logic               is_acc;

    always_comb begin
        is_acc  = (MDUOp == OP_MADD) || (MDUOp == OP_MADDU) ||
                  (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
        acc_sum = ((MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU)) ?
                  ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_BUSY;
            ST_BUSY: if (commit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        if (state_q == ST_IDLE) begin
            if (launch && (cls == CLS_DIV)) begin
                cnt_d     = CNT_W'(DIV_CYCLES);
                pend_hi_d = rem_s;
                pend_lo_d = quo_s;
                pend_ok_d = (B != '0);
            end else if (launch) begin
                cnt_d     = CNT_W'(MULT_CYCLES);
                pend_ok_d = 1'b1;
                {pend_hi_d, pend_lo_d} = prod;
`ifdef MDU_MADD_EN
                if (is_acc) {pend_hi_d, pend_lo_d} = acc_sum;
`endif
            end else if (Start && (MDUOp == OP_MTHI)) begin
                hi_d = A;
            end else if (Start && (MDUOp == OP_MTLO)) begin
                lo_d = A;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (commit && pend_ok_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end
    end

    assign Busy = (state_q == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: a reference model predicts {HI,LO} and Busy length for each op.
// Follows MDU_MADD_EN the same way the design does.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, Start;
    logic [3:0]  MDUOp;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int          vectors = 0;
    int          errors  = 0;
    logic [63:0] scb[$];
    logic [63:0] model_hl;

    mdu_hilo dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_next(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        int          sa, sbv;
        logic [63:0] r;
        r   = cur;
        sa  = a;
        sbv = b;
        case (op)
            OP_MULT:  r = longint'(sa) * longint'(sbv);
            OP_MULTU: r = {32'b0, a} * {32'b0, b};
            OP_DIV: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    r[31:0]  = sa / sbv;
                    r[63:32] = sa % sbv;
                end
            end
            OP_DIVU: if (b != 0) r = {a % b, a / b};
            OP_MTHI: r[63:32] = a;
            OP_MTLO: r[31:0]  = a;
`ifdef MDU_MADD_EN
            OP_MADD:  r = cur + longint'(sa) * longint'(sbv);
            OP_MADDU: r = cur + {32'b0, a} * {32'b0, b};
            OP_MSUB:  r = cur - longint'(sa) * longint'(sbv);
            OP_MSUBU: r = cur - {32'b0, a} * {32'b0, b};
`endif
            default: ;
        endcase
        return r;
    endfunction

    function automatic int exp_cyc(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: return 5;
            OP_DIV, OP_DIVU:   return 10;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 5;
`endif
            default: return 0;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the Start edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        model_hl = model_next(op, a, b, model_hl);
        scb.push_back(model_hl);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (Busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; Start = 1'b0; MDUOp = 4'h0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        vectors++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        vectors++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", HI); end
        vectors++; if (LO !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", LO); end
        Start = 1'b1; MDUOp = OP_MTHI; A = 32'hDEAD_BEEF;
        @(negedge clk);
        Start = 1'b0; MDUOp = OP_MULT; Start = 1'b1; A = 32'h3; B = 32'h3;
        @(negedge clk);
        Start = 1'b0; reset = 1'b0;
        vectors++; if (HI !== 32'h0) begin errors++; $display("FAIL reset_wins_mthi got=%h exp=0", HI); end
        vectors++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_wins_mult got=%b exp=0", Busy); end
        model_hl = '0;
    endtask

    task automatic test_arith;
        logic [3:0]  ops[6] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV};
        logic [31:0] as[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7};
        logic [31:0] bs[6]  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [63:0] fixed[6] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFE}, {32'h1, 32'hFFFF_FFFE},
                                  {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'h3},
                                  {32'h0, 32'h8000_0000}, {32'h1, 32'hFFFF_FFFD}};
        int cyc;
        logic [63:0] exp;
        for (int i = 0; i < 6; i++) begin
            predict(ops[i], as[i], bs[i]);
            issue(ops[i], as[i], bs[i]);
            wait_idle(cyc);
            vectors++;
            if (cyc != exp_cyc(ops[i])) begin
                errors++; $display("FAIL arith_busy[%0d] got=%0d exp=%0d", i, cyc, exp_cyc(ops[i]));
            end
            exp = scb.pop_front();
            vectors++;
            if ({HI, LO} !== exp || exp !== fixed[i]) begin
                errors++; $display("FAIL arith_hilo[%0d] got=%h exp=%h", i, {HI, LO}, fixed[i]);
            end
        end
    endtask

    task automatic test_move;
        predict(OP_MTHI, 32'h1234_5678, 32'h0);
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        vectors++; if (Busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", Busy); end
        vectors++;
        if ({HI, LO} !== scb.pop_front()) begin errors++; $display("FAIL mthi got=%h_%h exp_hi=12345678", HI, LO); end
        predict(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
        vectors++; if (Busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got=%b exp=0", Busy); end
        vectors++;
        if ({HI, LO} !== 64'h1234_5678_9ABC_DEF0) begin
            errors++; $display("FAIL mtlo got=%h_%h exp=12345678_9abcdef0", HI, LO);
        end
        void'(scb.pop_front());
    endtask

    task automatic test_divzero;
        int cyc;
        predict(OP_MTHI, 32'hAAAA, 0); issue(OP_MTHI, 32'hAAAA, 0); void'(scb.pop_front());
        predict(OP_MTLO, 32'h5555, 0); issue(OP_MTLO, 32'h5555, 0); void'(scb.pop_front());
        predict(OP_DIVU, 32'd7, 32'd0);
        issue(OP_DIVU, 32'd7, 32'd0);
        wait_idle(cyc);
        vectors++; if (cyc != 10) begin errors++; $display("FAIL divzero_busy got=%0d exp=10", cyc); end
        vectors++;
        if ({HI, LO} !== scb.pop_front() || {HI, LO} !== 64'h0000_AAAA_0000_5555) begin
            errors++; $display("FAIL divzero_hilo got=%h_%h exp=0000aaaa_00005555", HI, LO);
        end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        predict(OP_MULT, 32'h0000_1234, 32'h0000_0010);
        issue(OP_MULT, 32'h0000_1234, 32'h0000_0010);
        Start = 1'b1; MDUOp = OP_DIV; A = 32'd100; B = 32'd3;
        @(negedge clk);
        Start = 1'b1; MDUOp = OP_MTHI; A = 32'hFFFF_0000;
        @(negedge clk);
        Start = 1'b0;
        wait_idle(cyc);
        vectors++; if (cyc + 2 != 5) begin errors++; $display("FAIL busy_ignore_len got=%0d exp=5", cyc + 2); end
        vectors++;
        if ({HI, LO} !== scb.pop_front()) begin errors++; $display("FAIL busy_ignore_hilo got=%h_%h exp=00000000_00012340", HI, LO); end
        repeat (12) @(negedge clk);
        vectors++;
        if (Busy !== 1'b0 || {HI, LO} !== model_hl) begin
            errors++; $display("FAIL busy_ignore_late busy=%b got=%h_%h exp=%h", Busy, HI, LO, model_hl);
        end
    endtask

    task automatic test_reset_abort;
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_hl = '0;
        vectors++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            errors++; $display("FAIL abort_now busy=%b got=%h_%h exp=0", Busy, HI, LO);
        end
        repeat (12) @(negedge clk);
        vectors++;
        if (Busy !== 1'b0 || {HI, LO} !== 64'h0) begin
            errors++; $display("FAIL abort_late busy=%b got=%h_%h exp=0", Busy, HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        int cyc;
        predict(OP_MTHI, 32'h0BAD_F00D, 0); issue(OP_MTHI, 32'h0BAD_F00D, 0); void'(scb.pop_front());
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 10));
            if (i == 0) op = 4'hF;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 1) == 1) b = -b;
            predict(op, a, b);
            issue(op, a, b);
            wait_idle(cyc);
            vectors++;
            if (cyc != exp_cyc(op)) begin
                errors++; $display("FAIL b2b_busy[%0d] op=%h got=%0d exp=%0d", i, op, cyc, exp_cyc(op));
            end
            exp = scb.pop_front();
            vectors++;
            if ({HI, LO} !== exp) begin
                errors++; $display("FAIL b2b_hilo[%0d] op=%h a=%h b=%h got=%h exp=%h", i, op, a, b, {HI, LO}, exp);
            end
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDUOp = '0; A = '0; B = '0;
        model_hl = '0;
        @(negedge clk);
        test_reset;
        test_arith;
        test_move;
        test_divzero;
        test_start_while_busy;
        test_reset_abort;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
